position_ring_sequencer: RTL and testbench

//  Timestep sequencer for the position ring. Drives the shared 2-bit dispatch bus and double_buffer select
//  to all ring nodes, and monitors their per-node done/in-flight flags. Steps each batch: clear, prime,
//  run, drain, advance, and signals when every node has exhausted its cell.

---
 rtl/position_ring_sequencer_pkg.sv | 35 +++
 rtl/position_ring_sequencer_if.sv | 27 ++
 rtl/position_ring_sequencer_drain.sv | 27 ++
 rtl/position_ring_sequencer.sv | 134 +++++++++++++
 tb/tb_position_ring_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/position_ring_sequencer_pkg.sv
// Shared encodings for the position-ring timestep sequencer.
package ring_pkg;

    localparam int unsigned DISP_W = 2;

    typedef enum logic [DISP_W-1:0] {
        DISP_IDLE = 2'b00,
        DISP_ADV  = 2'b01,
        DISP_RUN  = 2'b10,
        DISP_CLR  = 2'b11
    } disp_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_ADV,
        S_FLUSH,
        S_DONE,
        S_ABRT
    } state_e;

    // Dispatch code broadcast to the ring while in a given state.
    function automatic disp_e disp_of(input state_e s);
        case (s)
            S_CLEAR, S_ABRT:         return DISP_CLR;
            S_PRIME, S_ADV:          return DISP_ADV;
            S_RUN, S_DRAIN, S_FLUSH: return DISP_RUN;
            default:                 return DISP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/position_ring_sequencer_if.sv
// Sequencer <-> controller/ring-node bundle: control, node status flags and the broadcast outputs.
interface position_ring_sequencer_if #(
    parameter int unsigned NNODES = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic [NNODES-1:0] done_batch;
    logic [NNODES-1:0] done_all;
    logic [NNODES-1:0] in_flight;
    logic [1:0]        dispatch;
    logic              double_buffer;
    logic              busy;
    logic              step_done;
    logic              error;
    logic [CNT_W-1:0]  batch_count;

    modport master (
        output start, abort, done_batch, done_all, in_flight,
        input  dispatch, double_buffer, busy, step_done, error, batch_count
    );

    modport slave (
        input  start, abort, done_batch, done_all, in_flight,
        output dispatch, double_buffer, busy, step_done, error, batch_count
    );
endinterface

// File: rtl/position_ring_sequencer_drain.sv
// Quiet-cycle counter: counts consecutive in_flight-free cycles while enabled, flags the threshold cycle.
module ring_drain_counter #(
    parameter int unsigned NNODES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic quiet_i,
    output logic hit_c
);
    localparam int unsigned DW = (NNODES > 1) ? $clog2(NNODES) : 1;
    localparam logic [DW-1:0] THRESH = DW'(NNODES - 1);

    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && quiet_i && (cnt_q != THRESH)) cnt_d = cnt_q + DW'(1);
    end

    assign hit_c = en_i && quiet_i && (cnt_q == THRESH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/position_ring_sequencer.sv
// Timestep sequencer for the position ring: clear, prime, run/drain/advance per batch, flush, done.
module position_ring_sequencer
    import ring_pkg::*;
#(
    parameter int unsigned NNODES    = 8,
    parameter int unsigned FLUSH_CYC = 16,
    parameter int unsigned WDOG_CYC  = 4096,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    position_ring_sequencer_if.slave  bus
);
    localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);
    localparam int unsigned FL_W = $clog2(FLUSH_CYC + 1);

    state_e           state_q, state_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [FL_W-1:0]  flush_q, flush_d;
    logic             all_done_q, all_done_d;
    disp_e            dispatch_q, dispatch_d;
    logic             dbuf_q, dbuf_d;
    logic             busy_q, busy_d;
    logic             step_done_q, step_done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain_hit_c;

    ring_drain_counter #(.NNODES(NNODES)) u_drain (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == S_DRAIN),
        .quiet_i (~|bus.in_flight),
        .hit_c   (drain_hit_c)
    );

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        flush_d    = flush_q;
        all_done_d = all_done_q;
        dbuf_d     = dbuf_q;
        error_d    = error_q;
        count_d    = count_q;

        if (bus.abort && (state_q != S_IDLE) && (state_q != S_ABRT)) begin
            state_d = S_ABRT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = S_CLEAR;
                        error_d = 1'b0;
                        count_d = '0;
                    end
                end
                S_CLEAR: state_d = S_PRIME;
                S_PRIME: begin
                    state_d = S_RUN;
                    wdog_d  = '0;
                end
                S_RUN, S_DRAIN: begin
                    // Watchdog spans RUN and DRAIN; it beats any progress made in the same cycle.
                    if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                        error_d = 1'b1;
                        state_d = S_ABRT;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                        if (state_q == S_RUN) begin
                            if (&bus.done_batch) state_d = S_DRAIN;
                        end else if (drain_hit_c) begin
                            all_done_d = &bus.done_all;
                            count_d    = (&count_q) ? count_q : count_q + CNT_W'(1);
                            state_d    = S_ADV;
                        end
                    end
                end
                S_ADV: begin
                    wdog_d  = '0;
                    flush_d = '0;
                    state_d = all_done_q ? S_FLUSH : S_RUN;
                end
                S_FLUSH: begin
                    if (flush_q == FL_W'(FLUSH_CYC - 1)) begin
                        state_d = S_DONE;
                        dbuf_d  = ~dbuf_q;
                    end else begin
                        flush_d = flush_q + FL_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ABRT:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        dispatch_d  = disp_of(state_d);
        busy_d      = (state_d != S_IDLE);
        step_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wdog_q      <= '0;
            flush_q     <= '0;
            all_done_q  <= 1'b0;
            dispatch_q  <= DISP_IDLE;
            dbuf_q      <= 1'b0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            flush_q     <= flush_d;
            all_done_q  <= all_done_d;
            dispatch_q  <= dispatch_d;
            dbuf_q      <= dbuf_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            error_q     <= error_d;
            count_q     <= count_d;
        end
    end

    assign bus.dispatch      = dispatch_q;
    assign bus.double_buffer = dbuf_q;
    assign bus.busy          = busy_q;
    assign bus.step_done     = step_done_q;
    assign bus.error         = error_q;
    assign bus.batch_count   = count_q;
endmodule

// File: tb/tb_position_ring_sequencer.sv
// Directed bench for position_ring_sequencer: normal steps, drain restart, multi-batch, watchdog, abort, reset.
module tb_position_ring_sequencer;
    localparam int unsigned NN = 8;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    position_ring_sequencer_if #(.NNODES(NN), .CNT_W(CW)) bus ();

    position_ring_sequencer #(
        .NNODES(NN), .FLUSH_CYC(16), .WDOG_CYC(64), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n cycles of dispatch=RUN with no completion pulse
    task automatic expect_run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_disp"}, 32'(bus.dispatch), 32'h2);
            chk({tag, "_sd"}, 32'(bus.step_done), 32'h0);
        end
    endtask

    // One single-batch timestep with all nodes finishing immediately
    task automatic full_step(input string tag, input logic exp_dbuf);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_clr"}, 32'(bus.dispatch), 32'h3);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
        chk({tag, "_errclr"}, 32'(bus.error), 32'h0);
        chk({tag, "_cnt0"}, 32'(bus.batch_count), 32'h0);
        tick();
        chk({tag, "_prime"}, 32'(bus.dispatch), 32'h1);
        tick();
        chk({tag, "_run"}, 32'(bus.dispatch), 32'h2);
        bus.done_batch = '1;
        bus.done_all   = '1;
        bus.start      = 1'b1;
        expect_run({tag, "_drain"}, 8);
        bus.start = 1'b0;
        tick();
        chk({tag, "_adv"}, 32'(bus.dispatch), 32'h1);
        chk({tag, "_cnt1"}, 32'(bus.batch_count), 32'h1);
        bus.done_batch = '0;
        bus.done_all   = '0;
        expect_run({tag, "_flush"}, 16);
        tick();
        chk({tag, "_done_disp"}, 32'(bus.dispatch), 32'h0);
        chk({tag, "_done_sd"}, 32'(bus.step_done), 32'h1);
        chk({tag, "_done_dbuf"}, 32'(bus.double_buffer), 32'(exp_dbuf));
        tick();
        chk({tag, "_idle_sd"}, 32'(bus.step_done), 32'h0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_idle_disp"}, 32'(bus.dispatch), 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.done_batch = '0;
        bus.done_all   = '0;
        bus.in_flight  = '0;
        tick();
        tick();
        chk("rst_disp", 32'(bus.dispatch), 32'h0);
        chk("rst_dbuf", 32'(bus.double_buffer), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_sd", 32'(bus.step_done), 32'h0);
        chk("rst_err", 32'(bus.error), 32'h0);
        chk("rst_cnt", 32'(bus.batch_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single-batch step: dbuf 0 -> 1
        full_step("t1", 1'b1);

        // Three batches, in_flight pulse mid-drain in the first
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t2_clr", 32'(bus.dispatch), 32'h3);
        tick();
        tick();
        chk("t2_run", 32'(bus.dispatch), 32'h2);
        bus.done_batch = '1;
        expect_run("t2_drain_a", 6);
        bus.in_flight = 8'h08;
        expect_run("t2_drain_b", 1);
        bus.in_flight = 8'h00;
        expect_run("t2_drain_c", 7);
        tick();
        chk("t2_adv1", 32'(bus.dispatch), 32'h1);
        chk("t2_cnt1", 32'(bus.batch_count), 32'h1);
        expect_run("t3_b2_a", 3);
        bus.done_all = '1;
        expect_run("t3_b2_b", 2);
        bus.done_all = 8'h7F;
        expect_run("t3_b2_c", 4);
        tick();
        chk("t3_adv2", 32'(bus.dispatch), 32'h1);
        chk("t3_cnt2", 32'(bus.batch_count), 32'h2);
        expect_run("t3_b3_a", 2);
        bus.done_all = '1;
        expect_run("t3_b3_b", 7);
        tick();
        chk("t3_adv3", 32'(bus.dispatch), 32'h1);
        chk("t3_cnt3", 32'(bus.batch_count), 32'h3);
        bus.done_batch = '0;
        bus.done_all   = '0;
        expect_run("t3_flush", 16);
        tick();
        chk("t3_done_sd", 32'(bus.step_done), 32'h1);
        chk("t3_done_dbuf", 32'(bus.double_buffer), 32'h0);
        tick();
        chk("t3_idle_busy", 32'(bus.busy), 32'h0);

        // Watchdog: done_batch never arrives
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("t4_run", 32'(bus.dispatch), 32'h2);
        expect_run("t4_wait", 63);
        chk("t4_noerr", 32'(bus.error), 32'h0);
        tick();
        chk("t4_abrt_disp", 32'(bus.dispatch), 32'h3);
        chk("t4_err", 32'(bus.error), 32'h1);
        chk("t4_abrt_sd", 32'(bus.step_done), 32'h0);
        tick();
        chk("t4_idle_disp", 32'(bus.dispatch), 32'h0);
        chk("t4_idle_busy", 32'(bus.busy), 32'h0);
        chk("t4_idle_sd", 32'(bus.step_done), 32'h0);
        chk("t4_err_sticky", 32'(bus.error), 32'h1);
        chk("t4_dbuf", 32'(bus.double_buffer), 32'h0);
        tick();
        chk("t4_err_hold", 32'(bus.error), 32'h1);

        // Next start clears error; abort in RUN with a concurrent start
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t5_errclr", 32'(bus.error), 32'h0);
        tick();
        tick();
        chk("t5_run", 32'(bus.dispatch), 32'h2);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        chk("t5_abrt_disp", 32'(bus.dispatch), 32'h3);
        chk("t5_abrt_busy", 32'(bus.busy), 32'h1);
        tick();
        chk("t5_idle_disp", 32'(bus.dispatch), 32'h0);
        chk("t5_idle_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("t5_abort_wins", 32'(bus.dispatch), 32'h0);
        chk("t5_abort_wins_busy", 32'(bus.busy), 32'h0);
        chk("t5_sd", 32'(bus.step_done), 32'h0);
        chk("t5_dbuf", 32'(bus.double_buffer), 32'h0);
        bus.abort = 1'b0;
        bus.start = 1'b0;

        // Reset during FLUSH
        full_step("t6_pre", 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.done_batch = '1;
        bus.done_all   = '1;
        expect_run("t6_drain", 8);
        tick();
        chk("t6_adv", 32'(bus.dispatch), 32'h1);
        bus.done_batch = '0;
        bus.done_all   = '0;
        expect_run("t6_flush", 5);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_disp", 32'(bus.dispatch), 32'h0);
        chk("t6_rst_dbuf", 32'(bus.double_buffer), 32'h0);
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        chk("t6_rst_cnt", 32'(bus.batch_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        full_step("t6_post", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
